ysyx_220053_ifu: RTL and testbench

YSYX_220053_IFU -- requirements
Module: ysyx_220053_ifu

---
 rtl/ysyx_220053_ifu.sv | 110 +++++++++++
 tb/tb_ysyx_220053_ifu.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM (REQ/WAIT/DROP) feeding a small
// in-order instruction buffer, with redirect flush and stale-response dropping.
module ysyx_220053_ifu #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [63:0]     fetch_pc_q, fetch_pc_d;
  logic [63:0]     inflight_pc_q, inflight_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     instr_mem_q [FIFO_DEPTH];
  logic [63:0]     pc_mem_q    [FIFO_DEPTH];
  logic            req_fire, push, pop;

  // Credit check: a request only goes out if its response is guaranteed a slot.
  assign imem_req_valid = rst_n & (state_q == StReq) & (count_q < DepthCnt) & ~redirect_valid;
  assign imem_req_addr  = {fetch_pc_q[63:2], 2'b00};
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign push           = (state_q == StWait) & imem_resp_valid & ~redirect_valid;
  assign instr_valid    = (count_q != '0) & ~redirect_valid;
  assign pop            = instr_valid & instr_ready;
  assign instr_o        = instr_mem_q[rd_ptr_q];
  assign pc_o           = pc_mem_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      // An in-flight request must still be drained; its response is thrown away.
      case (state_q)
        StWait, StDrop: state_d = imem_resp_valid ? StReq : StDrop;
        default:        state_d = StReq;
      endcase
    end else begin
      if (req_fire) begin
        state_d       = StWait;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 64'd4;
      end
      if ((state_q == StWait || state_q == StDrop) && imem_resp_valid) begin
        state_d = StReq;
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StReq;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      if (push) begin
        instr_mem_q[wr_ptr_q] <= imem_resp_data;
        pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Bench for ysyx_220053_ifu: memory model answering with addr[31:0] after a programmable
// latency, and a scoreboard of accepted fetch addresses checked against popped entries.
module tb_ysyx_220053_ifu;

  localparam logic [63:0] ResetPc = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_o;
  logic [63:0] pc_o;

  int          n_cmp;
  int          n_err;
  logic [95:0] sb_q[$];
  logic [63:0] exp_pc;
  int          mem_lat;

  logic        mem_pend;
  int          mem_cnt;
  logic [63:0] mem_addr;

  ysyx_220053_ifu #(
    .RESET_PC  (ResetPc),
    .FIFO_DEPTH(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_o        (instr_o),
    .pc_o           (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: one response per accepted request, mem_lat cycles of extra wait.
  assign imem_resp_valid = mem_pend && (mem_cnt == 0);
  assign imem_resp_data  = mem_addr[31:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= '0;
    end else if (imem_req_valid && imem_req_ready) begin
      mem_pend <= 1'b1;
      mem_cnt  <= mem_lat;
      mem_addr <= imem_req_addr;
    end else if (imem_resp_valid) begin
      mem_pend <= 1'b0;
    end else if (mem_pend && mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  // One clock: scoreboard observes the handshakes at the falling edge, then the
  // caller resumes just after the next rising edge.
  task automatic tick();
    logic [95:0] e;
    @(negedge clk);
    if (!rst_n) begin
      sb_q.delete();
      exp_pc = ResetPc;
    end else if (redirect_valid) begin
      n_cmp++;
      if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL redirect_gate: instr_valid=%b req_valid=%b, required 0/0",
                 instr_valid, imem_req_valid);
      end
      sb_q.delete();
      exp_pc = {redirect_pc[63:2], 2'b00};
    end else begin
      if (instr_valid && instr_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_pop: unexpected entry instr=%h pc=%h, required none", instr_o, pc_o);
        end else begin
          e = sb_q.pop_front();
          if ({instr_o, pc_o} !== e) begin
            n_err++;
            $display("FAIL sb_pop: got instr=%h pc=%h, required instr=%h pc=%h",
                     instr_o, pc_o, e[95:64], e[63:0]);
          end
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        n_cmp++;
        if (imem_req_addr !== exp_pc) begin
          n_err++;
          $display("FAIL sb_req_addr: got %h, required %h", imem_req_addr, exp_pc);
        end
        sb_q.push_back({exp_pc[31:0], exp_pc});
        exp_pc = exp_pc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    mem_lat        = 0;
    tick();
    tick();
    n_cmp += 4;
    if (imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid);
    end
    if (instr_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_instr_valid: got %b, required 0", instr_valid);
    end
    if (instr_o !== 32'h0) begin
      n_err++; $display("FAIL reset_instr_o: got %h, required 0", instr_o);
    end
    if (pc_o !== 64'h0) begin
      n_err++; $display("FAIL reset_pc_o: got %h, required 0", pc_o);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== ResetPc) begin
      n_err++;
      $display("FAIL first_req: valid=%b addr=%h, required 1 %h",
               imem_req_valid, imem_req_addr, ResetPc);
    end
  endtask

  task automatic test_stream();
    int pops[$];
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat        = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (instr_valid && instr_ready) pops.push_back(i);
      tick();
    end
    n_cmp++;
    if (pops.size() < 3) begin
      n_err++; $display("FAIL stream_count: got %0d pops, required >= 3", pops.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (pops[k] != 2 + 2 * k) begin
          n_err++; $display("FAIL stream_cycle%0d: got %0d, required %0d", k, pops[k], 2 + 2 * k);
        end
      end
    end
  endtask

  task automatic test_stall();
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat        = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) tick();
    n_cmp += 3;
    if (imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_req_valid: got %b, required 0", imem_req_valid);
    end
    if (sb_q.size() != 2) begin
      n_err++; $display("FAIL stall_accepted: got %0d requests, required 2", sb_q.size());
    end
    if (instr_valid !== 1'b1 || pc_o !== ResetPc) begin
      n_err++; $display("FAIL stall_head: valid=%b pc=%h, required 1 %h", instr_valid, pc_o, ResetPc);
    end
    instr_ready = 1'b1;
    #1;
    tick();
    n_cmp++;
    if (instr_valid !== 1'b1 || pc_o !== ResetPc + 64'd4) begin
      n_err++;
      $display("FAIL stall_second: valid=%b pc=%h, required 1 %h", instr_valid, pc_o, ResetPc + 64'd4);
    end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_redirect_wait();
    int k;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat        = 3;
    apply_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0103;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_err++; $display("FAIL rdw_instr_valid: got %b, required 0", instr_valid);
    end
    tick();
    redirect_valid = 1'b0;
    mem_lat        = 0;
    #1;
    k = 0;
    while (!imem_req_valid && k < 10) begin
      tick();
      k++;
    end
    n_cmp += 3;
    if (k != 3) begin
      n_err++; $display("FAIL rdw_req_delay: got %0d cycles, required 3", k);
    end
    if (imem_req_addr !== 64'h0000_0000_8000_0100) begin
      n_err++; $display("FAIL rdw_req_addr: got %h, required 0000000080000100", imem_req_addr);
    end
    if (instr_valid !== 1'b0) begin
      n_err++; $display("FAIL rdw_fifo_empty: got %b, required 0", instr_valid);
    end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_redirect_resp();
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat        = 0;
    apply_reset();
    tick();
    n_cmp++;
    if (imem_resp_valid !== 1'b1) begin
      n_err++; $display("FAIL rdr_setup: resp_valid=%b, required 1", imem_resp_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_2000;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp += 2;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0000_0000_8000_2000) begin
      n_err++;
      $display("FAIL rdr_req: valid=%b addr=%h, required 1 0000000080002000",
               imem_req_valid, imem_req_addr);
    end
    if (instr_valid !== 1'b0) begin
      n_err++; $display("FAIL rdr_no_push: instr_valid=%b, required 0", instr_valid);
    end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_req_stall();
    instr_ready    = 1'b1;
    imem_req_ready = 1'b0;
    mem_lat        = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== ResetPc) begin
        n_err++;
        $display("FAIL req_hold%0d: valid=%b addr=%h, required 1 %h",
                 i, imem_req_valid, imem_req_addr, ResetPc);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset_mid();
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat        = 0;
    apply_reset();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_outputs: instr_valid=%b req_valid=%b, required 0/0",
               instr_valid, imem_req_valid);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== ResetPc || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_restart: req=%b addr=%h instr_valid=%b, required 1 %h 0",
               imem_req_valid, imem_req_addr, instr_valid, ResetPc);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      mem_lat        = $urandom_range(0, 2);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 4095))};
      tick();
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    exp_pc         = ResetPc;
    mem_lat        = 0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_resp();
    test_req_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
